// File: rtl/sal_ref_ctrl.sv
// Auto-refresh controller: tREFI interval counting, refresh debt and REF/tRFC sequencing.
// Define SAL_REF_STATS_EN to add the ref_cnt / urg_cnt statistics outputs.
module sal_ref_ctrl #(
  parameter  int BK_CNT       = 4,
  parameter  int REFI_W       = 16,
  parameter  int RFC_W        = 9,
  parameter  int MAX_POSTPONE = 8,
  localparam int DEBT_W       = $clog2(MAX_POSTPONE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_en,
  input  logic [REFI_W-1:0] t_refi_m1,
  input  logic [RFC_W-1:0]  t_rfc_m1,
  input  logic [BK_CNT-1:0] bk_idle,
  input  logic              ref_gnt,
  output logic              ref_req,
  output logic              block_act,
  output logic              ref_busy,
  output logic              urgent,
  output logic [DEBT_W-1:0] debt,
  output logic              debt_ovf
`ifdef SAL_REF_STATS_EN
  ,
  output logic [15:0]       ref_cnt,
  output logic [15:0]       urg_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REQ,
    ST_RFC
  } state_e;

  state_e            state_q;
  logic              ref_req_q;
  logic              block_act_q;
  logic              ref_busy_q;
  logic [RFC_W-1:0]  rfc_q;

  logic [REFI_W-1:0] refi_q, refi_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q, ovf_d;

  logic              tick;
  logic              grant;
  logic              all_idle;
  logic              at_max;
  logic              start_ref;
  logic              urg_evt;

  assign all_idle  = &bk_idle;
  assign at_max    = (debt_q == DEBT_W'(MAX_POSTPONE));
  assign grant     = ref_req_q & ref_gnt;
  assign start_ref = (debt_q != '0) && all_idle;
  assign urg_evt   = (state_q == ST_IDLE) && !start_ref && at_max;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    refi_d = refi_q;
    tick   = 1'b0;
    if (ref_en) begin
      if (refi_q == '0) begin
        refi_d = t_refi_m1;
        tick   = 1'b1;
      end else begin
        refi_d = refi_q - REFI_W'(1);
      end
    end
  end

  // A tick at the postponement limit cannot add debt; it only records the overflow.
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    case ({tick, grant})
      2'b10: begin
        if (at_max) ovf_d  = 1'b1;
        else        debt_d = debt_q + DEBT_W'(1);
      end
      2'b01:   debt_d = debt_q - DEBT_W'(1);
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      refi_q <= t_refi_m1;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      refi_q <= refi_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Outputs are registered alongside the state so they always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ref_req_q   <= 1'b0;
      block_act_q <= 1'b0;
      ref_busy_q  <= 1'b0;
      rfc_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ref) begin
            state_q     <= ST_REQ;
            ref_req_q   <= 1'b1;
            block_act_q <= 1'b1;
          end else if (at_max) begin
            state_q     <= ST_DRAIN;
            block_act_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (all_idle) begin
            state_q   <= ST_REQ;
            ref_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ref_gnt) begin
            state_q    <= ST_RFC;
            ref_req_q  <= 1'b0;
            ref_busy_q <= 1'b1;
            rfc_q      <= t_rfc_m1;
          end else if (!all_idle) begin
            ref_req_q <= 1'b0;
            if (at_max) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q     <= ST_IDLE;
              block_act_q <= 1'b0;
            end
          end
        end
        ST_RFC: begin
          if (rfc_q == '0) begin
            state_q     <= ST_IDLE;
            ref_busy_q  <= 1'b0;
            block_act_q <= 1'b0;
          end else begin
            rfc_q <= rfc_q - RFC_W'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          ref_req_q   <= 1'b0;
          block_act_q <= 1'b0;
          ref_busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAL_REF_STATS_EN
  logic [15:0] ref_cnt_q;
  logic [15:0] urg_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
      urg_cnt_q <= '0;
    end else begin
      if (grant)   ref_cnt_q <= ref_cnt_q + 16'd1;
      if (urg_evt) urg_cnt_q <= urg_cnt_q + 16'd1;
    end
  end

  assign ref_cnt = ref_cnt_q;
  assign urg_cnt = urg_cnt_q;
`else
  logic unused_urg_evt;
  assign unused_urg_evt = urg_evt;
`endif

  assign ref_req   = ref_req_q;
  assign block_act = block_act_q;
  assign ref_busy  = ref_busy_q;
  assign urgent    = at_max;
  assign debt      = debt_q;
  assign debt_ovf  = ovf_q;

endmodule
